// File: rtl/rf_rx_frame_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rf_rx_frame_buf
//  Description : Receive frame buffer for an 802.15.4 radio. Captures the
//                length byte, body, LQI and RSSI from the radio RX FIFO read
//                sequence, then presents the body to a consumer as a
//                first-word fall-through read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_rx_frame_buf #(
    parameter int MAX_LEN = 127,
    parameter int MIN_LEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frm_start,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    input  logic       frm_abort,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [6:0] frm_len,
    output logic [7:0] lqi,
    output logic [7:0] rssi,
    output logic       frm_ready,
    output logic       frm_err,
    output logic       frm_drop,
    output logic       busy
);

    localparam logic [7:0] c_min_len = 8'(MIN_LEN);
    localparam logic [7:0] c_max_len = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_BODY  = 3'd2,
        ST_META  = 3'd3,
        ST_READY = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_mem [0:127];
    logic [6:0] r_wp;
    logic [6:0] r_rp;
    logic [6:0] r_frm_len;
    logic [7:0] r_lqi;
    logic [7:0] r_rssi;
    logic       r_meta_cnt;
    logic       r_frm_ready;
    logic       r_frm_err;
    logic       r_frm_drop;
    logic       r_busy;

    logic       w_len_ok;
    logic       w_rd_valid;
    logic [6:0] w_wp_plus1;
    logic       w_err_nxt;
    logic       w_drop_nxt;
    logic       w_wp_clr;
    logic       w_wp_inc;
    logic       w_len_ld;
    logic       w_meta_clr;
    logic       w_meta_inc;
    logic       w_lqi_ld;
    logic       w_rssi_ld;
    logic       w_rp_clr;
    logic       w_rp_inc;

    assign w_len_ok   = (byte_in >= c_min_len) && (byte_in <= c_max_len);
    assign w_wp_plus1 = r_wp + 7'd1;
    assign w_rd_valid = (r_state == ST_READY) && (r_rp < r_frm_len);

    assign rd_data    = r_mem[r_rp];
    assign rd_valid   = w_rd_valid;
    assign frm_len    = r_frm_len;
    assign lqi        = r_lqi;
    assign rssi       = r_rssi;
    assign frm_ready  = r_frm_ready;
    assign frm_err    = r_frm_err;
    assign frm_drop   = r_frm_drop;
    assign busy       = r_busy;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and datapath strobes; abort overrides every other input.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_drop_nxt  = 1'b0;
        w_wp_clr    = 1'b0;
        w_wp_inc    = 1'b0;
        w_len_ld    = 1'b0;
        w_meta_clr  = 1'b0;
        w_meta_inc  = 1'b0;
        w_lqi_ld    = 1'b0;
        w_rssi_ld   = 1'b0;
        w_rp_clr    = 1'b0;
        w_rp_inc    = 1'b0;
        if (frm_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frm_start) begin
                        w_state_nxt = ST_LEN;
                        w_wp_clr    = 1'b1;
                    end
                end
                ST_LEN, ST_BODY, ST_META: begin
                    if (frm_start) begin
                        // Restart a frame in progress without flagging an error.
                        w_state_nxt = ST_LEN;
                        w_wp_clr    = 1'b1;
                        w_meta_clr  = 1'b1;
                    end else if (byte_valid) begin
                        if (r_state == ST_LEN) begin
                            if (w_len_ok) begin
                                w_len_ld    = 1'b1;
                                w_state_nxt = ST_BODY;
                            end else begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end
                        end else if (r_state == ST_BODY) begin
                            w_wp_inc = 1'b1;
                            if (w_wp_plus1 == r_frm_len) begin
                                w_state_nxt = ST_META;
                                w_meta_clr  = 1'b1;
                            end
                        end else if (!r_meta_cnt) begin
                            w_lqi_ld   = 1'b1;
                            w_meta_inc = 1'b1;
                        end else begin
                            w_rssi_ld   = 1'b1;
                            w_rp_clr    = 1'b1;
                            w_state_nxt = ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    w_drop_nxt = frm_start;
                    if (rd_en && w_rd_valid) begin
                        w_rp_inc = 1'b1;
                        if (r_rp == r_frm_len - 7'd1) w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Body memory write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wp_inc) r_mem[r_wp] <= byte_in;
    end

    // Pointers, captured header/meta fields and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp        <= 7'd0;
            r_rp        <= 7'd0;
            r_frm_len   <= 7'd0;
            r_lqi       <= 8'd0;
            r_rssi      <= 8'd0;
            r_meta_cnt  <= 1'b0;
            r_frm_ready <= 1'b0;
            r_frm_err   <= 1'b0;
            r_frm_drop  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_wp_clr)        r_wp <= 7'd0;
            else if (w_wp_inc)   r_wp <= w_wp_plus1;
            if (w_rp_clr)        r_rp <= 7'd0;
            else if (w_rp_inc)   r_rp <= r_rp + 7'd1;
            if (w_len_ld)        r_frm_len <= byte_in[6:0];
            if (w_lqi_ld)        r_lqi <= byte_in;
            if (w_rssi_ld)       r_rssi <= byte_in;
            if (w_meta_clr)      r_meta_cnt <= 1'b0;
            else if (w_meta_inc) r_meta_cnt <= 1'b1;
            r_frm_ready <= (w_state_nxt == ST_READY);
            r_busy      <= (w_state_nxt == ST_LEN) || (w_state_nxt == ST_BODY) ||
                           (w_state_nxt == ST_META);
            r_frm_err   <= w_err_nxt;
            r_frm_drop  <= w_drop_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_rx_frame_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_rx_frame_buf
//  Description : Self-checking bench for rf_rx_frame_buf. Body bytes are
//                queued as they are written and compared as they are popped.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_rx_frame_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frm_start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       frm_abort = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [6:0] frm_len;
    logic [7:0] lqi;
    logic [7:0] rssi;
    logic       frm_ready;
    logic       frm_err;
    logic       frm_drop;
    logic       busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb [$];

    rf_rx_frame_buf #(.MAX_LEN(127), .MIN_LEN(5)) dut (
        .clk(clk), .rst(rst), .frm_start(frm_start), .byte_valid(byte_valid),
        .byte_in(byte_in), .frm_abort(frm_abort), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .frm_len(frm_len),
        .lqi(lqi), .rssi(rssi), .frm_ready(frm_ready), .frm_err(frm_err),
        .frm_drop(frm_drop), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frm_start = 1'b1;
        tick();
        frm_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    // Full read sequence; body bytes are base, base+1, ... and optionally queued.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] base,
                              input logic [7:0] q, input logic [7:0] r, input bit push);
        pulse_start();
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            if (push) sb.push_back(base + 8'(i));
            send_byte(base + 8'(i));
        end
        send_byte(q);
        send_byte(r);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (frm_ready !== 1'b0) begin n_fail++; $display("FAIL reset_frm_ready: got %0h want 0", frm_ready); end
        n_tests++; if (rd_valid  !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0h want 0", rd_valid); end
        n_tests++; if (busy      !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
        n_tests++; if (frm_err   !== 1'b0) begin n_fail++; $display("FAIL reset_frm_err: got %0h want 0", frm_err); end
        n_tests++; if (frm_drop  !== 1'b0) begin n_fail++; $display("FAIL reset_frm_drop: got %0h want 0", frm_drop); end
        n_tests++; if (frm_len   !== 7'd0) begin n_fail++; $display("FAIL reset_frm_len: got %0h want 0", frm_len); end
        n_tests++; if ({lqi, rssi} !== 16'd0) begin n_fail++; $display("FAIL reset_meta: got %0h want 0", {lqi, rssi}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_good_frame(input string tag);
        logic [7:0] exp;
        int         n;
        pulse_start();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_len: got %0h want 1", tag, busy); end
        send_byte(8'h05);
        for (int i = 0; i < 5; i++) begin
            sb.push_back(8'hA1 + 8'(i));
            send_byte(8'hA1 + 8'(i));
        end
        send_byte(8'h40);
        n_tests++; if (frm_ready !== 1'b0) begin n_fail++; $display("FAIL %s_early_ready: got %0h want 0", tag, frm_ready); end
        send_byte(8'hC8);
        n_tests++; if (frm_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %0h want 1", tag, frm_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_ready: got %0h want 0", tag, busy); end
        n_tests++; if (frm_len !== 7'd5) begin n_fail++; $display("FAIL %s_len: got %0d want 5", tag, frm_len); end
        n_tests++; if (lqi !== 8'h40) begin n_fail++; $display("FAIL %s_lqi: got %0h want 40", tag, lqi); end
        n_tests++; if (rssi !== 8'hC8) begin n_fail++; $display("FAIL %s_rssi: got %0h want c8", tag, rssi); end
        n = 0;
        while (rd_valid === 1'b1 && n < 200) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            n_tests++; if (rd_data !== exp) begin n_fail++; $display("FAIL %s_data[%0d]: got %0h want %0h", tag, n, rd_data, exp); end
            rd_en = 1'b1; tick(); rd_en = 1'b0; n++;
        end
        n_tests++; if (sb.size() != 0 || n != 5) begin n_fail++; $display("FAIL %s_pops: got %0d want 5", tag, n); sb.delete(); end
        n_tests++; if (frm_ready !== 1'b0) begin n_fail++; $display("FAIL %s_ready_fall: got %0h want 0", tag, frm_ready); end
    endtask

    task automatic test_bad_len();
        logic [7:0] bad [2] = '{8'h80, 8'h03};
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            send_byte(bad[k]);
            n_tests++; if (frm_err !== 1'b1) begin n_fail++; $display("FAIL badlen_%0h_err: got %0h want 1", bad[k], frm_err); end
            n_tests++; if (busy !== 1'b0 || frm_ready !== 1'b0) begin n_fail++; $display("FAIL badlen_%0h_state: got busy=%0h ready=%0h want 0", bad[k], busy, frm_ready); end
            tick();
            n_tests++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL badlen_%0h_pulse: got %0h want 0", bad[k], frm_err); end
        end
    endtask

    task automatic test_max_frame();
        logic [7:0] exp;
        int         n;
        send_frame(8'd127, 8'h17, 8'h5A, 8'hA5, 1'b1);
        n_tests++; if (frm_ready !== 1'b1 || frm_len !== 7'd127) begin n_fail++; $display("FAIL max_ready: got ready=%0h len=%0d want 1/127", frm_ready, frm_len); end
        n = 0;
        while (rd_valid === 1'b1 && n < 300) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            n_tests++; if (rd_data !== exp) begin n_fail++; $display("FAIL max_data[%0d]: got %0h want %0h", n, rd_data, exp); end
            rd_en = 1'b1; tick(); rd_en = 1'b0; n++;
        end
        n_tests++; if (sb.size() != 0 || n != 127) begin n_fail++; $display("FAIL max_pops: got %0d want 127", n); sb.delete(); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_tests++; if (rd_valid !== 1'b0 || frm_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL max_extra_pop: got valid=%0h ready=%0h busy=%0h want 0", rd_valid, frm_ready, busy); end
    endtask

    task automatic test_drop();
        logic [7:0] exp;
        int         n;
        send_frame(8'd6, 8'h30, 8'h11, 8'h22, 1'b1);
        pulse_start();
        n_tests++; if (frm_drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %0h want 1", frm_drop); end
        n_tests++; if (frm_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_held: got ready=%0h busy=%0h want 1/0", frm_ready, busy); end
        tick();
        n_tests++; if (frm_drop !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_end: got %0h want 0", frm_drop); end
        n_tests++; if (lqi !== 8'h11 || rssi !== 8'h22 || frm_len !== 7'd6) begin n_fail++; $display("FAIL drop_meta: got %0h/%0h/%0d want 11/22/6", lqi, rssi, frm_len); end
        n = 0;
        while (rd_valid === 1'b1 && n < 200) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            n_tests++; if (rd_data !== exp) begin n_fail++; $display("FAIL drop_data[%0d]: got %0h want %0h", n, rd_data, exp); end
            rd_en = 1'b1; tick(); rd_en = 1'b0; n++;
        end
        n_tests++; if (sb.size() != 0 || n != 6) begin n_fail++; $display("FAIL drop_pops: got %0d want 6", n); sb.delete(); end
    endtask

    task automatic test_abort_restart();
        logic [7:0] exp;
        int         n;
        pulse_start();
        send_byte(8'h05);
        send_byte(8'hE0);
        send_byte(8'hE1);
        frm_abort = 1'b1; byte_valid = 1'b1; byte_in = 8'hE2;
        tick();
        frm_abort = 1'b0; byte_valid = 1'b0;
        n_tests++; if (busy !== 1'b0 || frm_ready !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%0h ready=%0h want 0", busy, frm_ready); end
        send_byte(8'h07);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_byte: got busy=%0h want 0", busy); end
        pulse_start();
        send_byte(8'h06);
        send_byte(8'hB1);
        send_byte(8'hB2);
        send_frame(8'd5, 8'hC1, 8'h33, 8'h44, 1'b1);
        n_tests++; if (frm_err !== 1'b0 || frm_ready !== 1'b1 || frm_len !== 7'd5) begin n_fail++; $display("FAIL restart_ready: got err=%0h ready=%0h len=%0d want 0/1/5", frm_err, frm_ready, frm_len); end
        n = 0;
        while (rd_valid === 1'b1 && n < 200) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            n_tests++; if (rd_data !== exp) begin n_fail++; $display("FAIL restart_data[%0d]: got %0h want %0h", n, rd_data, exp); end
            rd_en = 1'b1; tick(); rd_en = 1'b0; n++;
        end
        n_tests++; if (sb.size() != 0 || n != 5) begin n_fail++; $display("FAIL restart_pops: got %0d want 5", n); sb.delete(); end
    endtask

    task automatic test_async_reset();
        pulse_start();
        send_byte(8'h08);
        send_byte(8'h91);
        send_byte(8'h92);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0 || frm_len !== 7'd0) begin n_fail++; $display("FAIL async_rst_clear: got busy=%0h len=%0d want 0/0", busy, frm_len); end
        tick();
        rst = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0 || frm_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_idle: got busy=%0h ready=%0h want 0", busy, frm_ready); end
        test_good_frame("post_rst");
    endtask

    initial begin
        test_reset();
        test_good_frame("good");
        test_bad_len();
        test_max_frame();
        test_drop();
        test_abort_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_rx_frame_buf.md
RF_RX_FRAME_BUF -- requirements
Module: rf_rx_frame_buf

Interface
REQ-001 Parameter MAX_LEN, default 127, meaning largest legal 802.15.4 frame length byte (MHR+payload+FCS).
REQ-002 Parameter MIN_LEN, default 5, meaning smallest legal frame length byte.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 frm_start  in  1  one-cycle pulse; radio RX FIFO read sequence begins.
REQ-006 byte_valid  in  1  one-cycle strobe; byte_in holds one byte read from the radio RX FIFO.
REQ-007 byte_in  in  8  RX FIFO byte, in order: length, len body bytes, LQI, RSSI.
REQ-008 frm_abort  in  1  discard the current frame and return to IDLE.
REQ-009 rd_en  in  1  consumer pop request.
REQ-010 rd_data  out  8  body byte at read pointer (first-word fall-through).
REQ-011 rd_valid  out  1  rd_data holds an unread body byte.
REQ-012 frm_len  out  7  length byte of the buffered frame.
REQ-013 lqi, rssi  out  8 each  link quality and RSSI bytes of the buffered frame.
REQ-014 frm_ready  out  1  a complete, valid frame is held.
REQ-015 frm_err  out  1  one-cycle pulse; length byte out of range.
REQ-016 frm_drop  out  1  one-cycle pulse; frm_start refused because a frame is held.
REQ-017 busy  out  1  high in LEN, BODY, META.

Function
REQ-018 States: IDLE, LEN, BODY, META, READY; 128x8 body memory, 7-bit write pointer wp, 7-bit read pointer rp.
REQ-019 IDLE: frm_start -> LEN, wp=0; byte_valid is ignored.
REQ-020 LEN: byte_valid with MIN_LEN <= byte_in <= MAX_LEN -> store frm_len=byte_in[6:0], go to BODY.
REQ-021 LEN: byte_valid with byte_in outside [MIN_LEN, MAX_LEN] (bit7 set included) -> frm_err pulse next cycle, go to IDLE.
REQ-022 BODY: each byte_valid writes mem[wp] and increments wp; the byte that makes wp equal frm_len -> META, with a META sub-count of 0.
REQ-023 META: first byte_valid -> lqi, second -> rssi; after the second -> READY, rp=0.
REQ-024 READY: frm_ready=1; rd_valid=1 while rp<frm_len; rd_data=mem[rp] combinationally.
REQ-025 rd_en with rd_valid=1 increments rp; rd_en with rd_valid=0 is ignored.
REQ-026 Pop of the last byte (rp=frm_len-1) -> IDLE next cycle; frm_ready and rd_valid fall the same edge.
REQ-027 frm_start in READY -> ignored, frm_drop pulse next cycle; the held frame is unaffected.
REQ-028 frm_start in LEN/BODY/META -> restart: wp=0, META count=0, go to LEN; no error pulse.
REQ-029 frm_abort in any state -> IDLE next cycle; it has priority over frm_start, byte_valid and rd_en in the same cycle.
REQ-030 byte_valid and rd_en never interact: writes occur only in BODY, reads only in READY.
REQ-031 frm_len, lqi and rssi hold their values until the next accepted length byte or reset.
REQ-032 All outputs are registered except rd_data and rd_valid, which decode from rp, frm_len and state.

Reset
REQ-033 rst=1 immediately forces IDLE, wp=rp=0, frm_len=0, lqi=rssi=0, frm_ready=rd_valid=frm_err=frm_drop=busy=0.
REQ-034 Memory contents are not reset; rd_data is don't-care while rd_valid=0.
REQ-035 rst asserted mid-frame or mid-drain discards the frame; after release the block waits in IDLE for frm_start.

Verification
REQ-036 Good frame: frm_start, bytes 0x05,A1,A2,A3,A4,A5,0x40,0xC8 -> frm_ready=1, frm_len=5, lqi=0x40, rssi=0xC8; five rd_en pops return A1..A5, then frm_ready=0.
REQ-037 Bad length: frm_start, byte 0x80 (and separately 0x03) -> frm_err single pulse, state IDLE, frm_ready=0.
REQ-038 Max frame: length 127 with 127 body bytes plus 2 meta bytes -> 127 pops in order, no wp wrap corruption; rd_en after the last pop is ignored.
REQ-039 Drop: frame held, frm_start pulsed -> frm_drop pulse, the held frame drains intact.
REQ-040 Abort/restart: frm_abort with byte_valid in BODY -> IDLE and byte not stored; frm_start in BODY then a new 0x05 frame -> only the new frame is delivered.
REQ-041 Async reset asserted between clock edges during BODY -> outputs clear before the next edge; a following good frame passes as in REQ-036.
